// File: rtl/matrix_sched_pkg.sv
// rtl/matrix_sched_pkg.sv - shared types and width helpers for matrix_stream_scheduler
package matrix_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } sched_state_t;

  function automatic int FRAME_BEATS(input int size);
    return size * size;
  endfunction

  // $clog2 clamped to 1 so a degenerate parameter still yields a legal vector
  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sched_tag_fifo.sv
// rtl/sched_tag_fifo.sv - owner-tag FIFO for frames in flight inside the engine
module sched_tag_fifo
  import matrix_sched_pkg::*;
#(
  parameter int TAG_W = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [TAG_W-1:0] din,
  output logic [TAG_W-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/matrix_stream_scheduler.sv
// rtl/matrix_stream_scheduler.sv - round-robin frame scheduler sharing one reverse_matrix engine
module matrix_stream_scheduler
  import matrix_sched_pkg::*;
#(
  parameter int SIZE       = 6,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 2,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_REQ-1:0]            s_tvalid,
  input  logic [NUM_REQ-1:0]            s_tlast,
  output logic [NUM_REQ-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         eng_in_tdata,
  output logic                          eng_in_tvalid,
  output logic                          eng_in_tlast,
  input  logic                          eng_in_tready,
  input  logic [DATA_WIDTH-1:0]         eng_out_tdata,
  input  logic                          eng_out_tvalid,
  input  logic                          eng_out_tlast,
  output logic                          eng_out_tready,
  output logic [NUM_REQ*DATA_WIDTH-1:0] m_tdata,
  output logic [NUM_REQ-1:0]            m_tvalid,
  output logic [NUM_REQ-1:0]            m_tlast,
  input  logic [NUM_REQ-1:0]            m_tready,
  output logic                          busy,
  output logic [NUM_REQ-1:0]            tlast_err
);

  localparam int BEATS  = FRAME_BEATS(SIZE);
  localparam int BEAT_W = clog2_min1(BEATS);
  localparam int TAG_W  = clog2_min1(NUM_REQ);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [TAG_W-1:0]  LAST_REQ  = TAG_W'(NUM_REQ - 1);

  sched_state_t        state;
  sched_state_t        state_nxt;
  logic [TAG_W-1:0]    gnt;
  logic [TAG_W-1:0]    rr_ptr;
  logic [TAG_W-1:0]    pick;
  logic [TAG_W-1:0]    pick_hi;
  logic [TAG_W-1:0]    pick_lo;
  logic                hi_valid;
  logic                lo_valid;
  logic                pick_valid;
  logic [TAG_W-1:0]    head;
  logic [BEAT_W-1:0]   beat_cnt;
  logic                grant;
  logic                req_valid;
  logic                req_last;
  logic                beat_acc;
  logic                last_beat;
  logic                fifo_full;
  logic                fifo_empty;
  logic                tag_pop;
  logic [NUM_REQ-1:0]  err_set;

  // Lowest valid index above rr_ptr wins, else lowest at or below it (wrap)
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (s_tvalid[i]) begin
        if (TAG_W'(i) > rr_ptr) begin
          pick_hi  = TAG_W'(i);
          hi_valid = 1'b1;
        end else begin
          pick_lo  = TAG_W'(i);
          lo_valid = 1'b1;
        end
      end
    end
    pick_valid = hi_valid || lo_valid;
    pick       = hi_valid ? pick_hi : pick_lo;
  end

  assign grant     = (state == IDLE) && !fifo_full && pick_valid;
  assign last_beat = (beat_cnt == LAST_BEAT);

  always_comb begin
    req_valid    = 1'b0;
    req_last     = 1'b0;
    eng_in_tdata = '0;
    s_tready     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (TAG_W'(i) == gnt) begin
        req_valid    = s_tvalid[i];
        req_last     = s_tlast[i];
        eng_in_tdata = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        if (state == STREAM) s_tready[i] = eng_in_tready;
      end
    end
  end

  assign eng_in_tvalid = (state == STREAM) && req_valid;
  assign eng_in_tlast  = (state == STREAM) && last_beat;
  assign beat_acc      = eng_in_tvalid && eng_in_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = STREAM;
      STREAM:  if (beat_acc && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame length is set by the beat count; requester tlast is only audited
  always_comb begin
    err_set = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (beat_acc && (TAG_W'(i) == gnt) && (req_last != last_beat)) err_set[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      rr_ptr    <= LAST_REQ;
      beat_cnt  <= '0;
      tlast_err <= '0;
    end else begin
      if (grant) begin
        gnt      <= pick;
        rr_ptr   <= pick;
        beat_cnt <= '0;
      end else if (beat_acc) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
      tlast_err <= tlast_err | err_set;
    end
  end

  sched_tag_fifo #(
    .TAG_W (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .pop   (tag_pop),
    .din   (pick),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Engine results go to whichever requester owns the oldest frame in flight
  always_comb begin
    m_tvalid       = '0;
    m_tlast        = '0;
    eng_out_tready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!fifo_empty && (head == TAG_W'(i))) begin
        m_tvalid[i]    = eng_out_tvalid;
        m_tlast[i]     = eng_out_tlast;
        eng_out_tready = m_tready[i];
      end
    end
  end

  assign m_tdata = {NUM_REQ{eng_out_tdata}};
  assign tag_pop = eng_out_tvalid && eng_out_tready && eng_out_tlast;
  assign busy    = (state == STREAM) || !fifo_empty;

endmodule

// File: tb/tb_matrix_stream_scheduler.sv
// tb/tb_matrix_stream_scheduler.sv - scoreboard bench for matrix_stream_scheduler
module tb_matrix_stream_scheduler;

  localparam int SIZE  = 6;
  localparam int DW    = 8;
  localparam int NR    = 2;
  localparam int TD    = 4;
  localparam int BEATS = SIZE * SIZE;

  logic           clk_tb;
  logic           rst;
  logic [NR*DW-1:0] s_tdata;
  logic [NR-1:0]  s_tvalid;
  logic [NR-1:0]  s_tlast;
  logic [NR-1:0]  s_tready;
  logic [DW-1:0]  eng_in_tdata;
  logic           eng_in_tvalid;
  logic           eng_in_tlast;
  logic           eng_in_tready;
  logic [DW-1:0]  eng_out_tdata;
  logic           eng_out_tvalid;
  logic           eng_out_tlast;
  logic           eng_out_tready;
  logic [NR*DW-1:0] m_tdata;
  logic [NR-1:0]  m_tvalid;
  logic [NR-1:0]  m_tlast;
  logic [NR-1:0]  m_tready;
  logic           busy;
  logic [NR-1:0]  tlast_err;

  int total;
  int bad;
  int cyc;
  int req_target [NR];
  int req_done   [NR];
  int req_beat   [NR];
  int tl_pos     [NR];
  bit eng_en;
  logic [DW-1:0] in_buf [$];
  logic [DW-1:0] out_q  [$];
  int out_cnt;
  int last_end_cyc;
  int grant_log [$];
  int gap_log   [$];
  logic [DW-1:0] exp_d [NR][$];
  bit            exp_l [NR][$];
  int mon_idx [NR];
  int mon_cnt [NR];

  matrix_stream_scheduler #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .TAG_DEPTH  (TD)
  ) dut (
    .clk            (clk_tb),
    .rst            (rst),
    .s_tdata        (s_tdata),
    .s_tvalid       (s_tvalid),
    .s_tlast        (s_tlast),
    .s_tready       (s_tready),
    .eng_in_tdata   (eng_in_tdata),
    .eng_in_tvalid  (eng_in_tvalid),
    .eng_in_tlast   (eng_in_tlast),
    .eng_in_tready  (eng_in_tready),
    .eng_out_tdata  (eng_out_tdata),
    .eng_out_tvalid (eng_out_tvalid),
    .eng_out_tlast  (eng_out_tlast),
    .eng_out_tready (eng_out_tready),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tlast        (m_tlast),
    .m_tready       (m_tready),
    .busy           (busy),
    .tlast_err      (tlast_err)
  );

  initial begin
    clk_tb = 1'b0;
    forever #5 clk_tb = ~clk_tb;
  end

  function automatic logic [DW-1:0] dat(input int r, input int f, input int b);
    return DW'((r * 97 + f * 31 + b * 5) % 256);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_tready"}, 32'(s_tready), 0);
    check({tag, "_m_tvalid"}, 32'(m_tvalid), 0);
    check({tag, "_m_tlast"}, 32'(m_tlast), 0);
    check({tag, "_eng_in_tvalid"}, 32'(eng_in_tvalid), 0);
    check({tag, "_eng_in_tlast"}, 32'(eng_in_tlast), 0);
    check({tag, "_eng_out_tready"}, 32'(eng_out_tready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_tlast_err"}, 32'(tlast_err), 0);
  endtask

  // Queue the reversed engine result of each frame the requester will send
  task automatic send(input int r, input int n);
    int first;
    first = req_target[r];
    for (int f = first; f < first + n; f++) begin
      for (int k = 0; k < BEATS; k++) begin
        exp_d[r].push_back(dat(r, f, BEATS - 1 - k));
        exp_l[r].push_back(k == BEATS - 1);
      end
    end
    req_target[r] = first + n;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(posedge clk_tb); #2;
      n++;
      done = !busy && (in_buf.size() == 0) && (out_q.size() == 0);
      for (int r = 0; r < NR; r++)
        if (req_done[r] != req_target[r] || mon_idx[r] != exp_d[r].size()) done = 1'b0;
    end
    check(name, 32'(done), 1);
  endtask

  task automatic do_reset();
    @(posedge clk_tb); #2;
    rst = 1'b1;
    for (int r = 0; r < NR; r++) req_target[r] = 0;
    repeat (2) @(posedge clk_tb);
    #2 rst = 1'b0;
  endtask

  // Requester and engine models: sample at negedge, drive just after posedge
  initial begin : env
    int owner;
    forever begin
      @(negedge clk_tb);
      cyc++;
      if (rst) begin
        for (int r = 0; r < NR; r++) begin
          req_done[r] = 0;
          req_beat[r] = 0;
        end
        in_buf.delete();
        out_q.delete();
        out_cnt = 0;
      end else begin
        if (eng_in_tvalid && eng_in_tready) begin
          owner = -1;
          for (int r = 0; r < NR; r++) if (s_tready[r]) owner = r;
          check("in_owner_onehot", 32'($countones(s_tready)), 1);
          if (owner >= 0) begin
            if (in_buf.size() == 0) begin
              grant_log.push_back(owner);
              gap_log.push_back(cyc - last_end_cyc);
            end
            check("in_data", 32'(eng_in_tdata), 32'(dat(owner, req_done[owner], req_beat[owner])));
          end
          in_buf.push_back(eng_in_tdata);
          check("in_tlast", 32'(eng_in_tlast), 32'(in_buf.size() == BEATS));
          if (in_buf.size() == BEATS) begin
            for (int k = 0; k < BEATS; k++) out_q.push_back(in_buf[BEATS - 1 - k]);
            in_buf.delete();
            last_end_cyc = cyc;
          end
        end
        for (int r = 0; r < NR; r++) begin
          if (s_tvalid[r] && s_tready[r]) begin
            if (req_beat[r] == BEATS - 1) begin
              req_beat[r] = 0;
              req_done[r]++;
            end else begin
              req_beat[r]++;
            end
          end
        end
        if (eng_out_tvalid && eng_out_tready) begin
          void'(out_q.pop_front());
          out_cnt = (out_cnt == BEATS - 1) ? 0 : out_cnt + 1;
        end
      end
      @(posedge clk_tb); #1;
      for (int r = 0; r < NR; r++) begin
        if (!rst && req_done[r] < req_target[r]) begin
          s_tvalid[r] = 1'b1;
          s_tdata[r*DW +: DW] = dat(r, req_done[r], req_beat[r]);
          s_tlast[r] = (req_beat[r] == tl_pos[r]);
        end else begin
          s_tvalid[r] = 1'b0;
          s_tdata[r*DW +: DW] = '0;
          s_tlast[r] = 1'b0;
        end
      end
      if (!rst && eng_en && out_q.size() > 0) begin
        eng_out_tvalid = 1'b1;
        eng_out_tdata  = out_q[0];
        eng_out_tlast  = (out_cnt == BEATS - 1);
      end else begin
        eng_out_tvalid = 1'b0;
        eng_out_tdata  = '0;
        eng_out_tlast  = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk_tb);
      if (rst) begin
        for (int r = 0; r < NR; r++) mon_idx[r] = exp_d[r].size();
      end else begin
        if (m_tvalid != '0) check("m_onehot", 32'($countones(m_tvalid)), 1);
        for (int r = 0; r < NR; r++) begin
          if (m_tvalid[r] && m_tready[r]) begin
            mon_cnt[r]++;
            if (mon_idx[r] >= exp_d[r].size()) begin
              check("m_unexpected_beat", 32'(r), 32'(NR));
            end else begin
              check("m_data", 32'(m_tdata[r*DW +: DW]), 32'(exp_d[r][mon_idx[r]]));
              check("m_tlast", 32'(m_tlast[r]), 32'(exp_l[r][mon_idx[r]]));
              mon_idx[r]++;
            end
          end
        end
      end
    end
  end

  initial begin : main
    int base;
    int n;
    int held;
    total = 0;
    bad = 0;
    cyc = 0;
    last_end_cyc = 0;
    rst = 1'b1;
    s_tdata = '0;
    s_tvalid = '0;
    s_tlast = '0;
    eng_in_tready = 1'b1;
    eng_out_tdata = '0;
    eng_out_tvalid = 1'b0;
    eng_out_tlast = 1'b0;
    m_tready = '1;
    eng_en = 1'b1;
    for (int r = 0; r < NR; r++) tl_pos[r] = BEATS - 1;
    repeat (3) @(posedge clk_tb);
    #2;
    check_reset_vals("reset");
    rst = 1'b0;

    // single frame from requester 0
    send(0, 1);
    wait_idle(300, "t1_idle");
    check("t1_grants", 32'(grant_log.size()), 1);
    check("t1_tlast_err", 32'(tlast_err), 0);
    check("t1_busy", 32'(busy), 0);

    // round robin, both requesters valid straight out of reset
    do_reset();
    base = grant_log.size();
    send(0, 4);
    send(1, 4);
    wait_idle(2000, "t2_idle");
    check("t2_grants", 32'(grant_log.size() - base), 8);
    for (int i = 0; i < 8 && base + i < grant_log.size(); i++) begin
      check("t2_order", 32'(grant_log[base + i]), 32'(i % 2));
      if (i > 0) check("t2_bubble", 32'(gap_log[base + i]), 2);
    end

    // output backpressure on requester 0 while requester 1 has a frame queued
    base = mon_cnt[0];
    send(0, 1);
    send(1, 1);
    n = 0;
    while (mon_cnt[0] < base + 5 && n < 500) begin
      @(posedge clk_tb); #2;
      n++;
    end
    check("t3_result_started", 32'(mon_cnt[0] >= base + 5), 1);
    m_tready[0] = 1'b0;
    held = mon_cnt[0];
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t3_eng_out_tready", 32'(eng_out_tready), 0);
      check("t3_m_tvalid1", 32'(m_tvalid[1]), 0);
      check("t3_m_tvalid0", 32'(m_tvalid[0]), 1);
      @(posedge clk_tb); #2;
    end
    check("t3_no_beats_while_stalled", 32'(mon_cnt[0]), 32'(held));
    m_tready[0] = 1'b1;
    wait_idle(1000, "t3_idle");

    // tag FIFO full: engine output frozen, five frames offered
    base = grant_log.size();
    eng_en = 1'b0;
    send(0, 5);
    repeat (220) @(posedge clk_tb);
    #2;
    check("t4_grants_while_full", 32'(grant_log.size() - base), 4);
    check("t4_s_tvalid0", 32'(s_tvalid[0]), 1);
    check("t4_s_tready0", 32'(s_tready[0]), 0);
    check("t4_busy", 32'(busy), 1);
    eng_en = 1'b1;
    n = 0;
    while (grant_log.size() < base + 5 && n < 120) begin
      @(posedge clk_tb); #2;
      n++;
    end
    check("t4_grant_after_pop", 32'(grant_log.size() - base), 5);
    wait_idle(1000, "t4_idle");

    // misplaced tlast on requester 1 (beat 20)
    tl_pos[1] = 19;
    send(1, 1);
    wait_idle(300, "t5_idle");
    check("t5_tlast_err", 32'(tlast_err), 32'(2'b10));
    tl_pos[1] = BEATS - 1;

    // reset in the middle of a frame
    send(0, 1);
    n = 0;
    while (req_beat[0] < 17 && n < 200) begin
      @(posedge clk_tb); #2;
      n++;
    end
    check("t6_reached_beat17", 32'(req_beat[0]), 17);
    check("t6_busy_before_reset", 32'(busy), 1);
    rst = 1'b1;
    for (int r = 0; r < NR; r++) req_target[r] = 0;
    #1;
    check_reset_vals("t6_async");
    repeat (2) @(posedge clk_tb);
    #2 rst = 1'b0;
    base = grant_log.size();
    send(0, 1);
    send(1, 1);
    wait_idle(500, "t6_idle");
    check("t6_grants", 32'(grant_log.size() - base), 2);
    if (grant_log.size() >= base + 2) begin
      check("t6_first_grant", 32'(grant_log[base]), 0);
      check("t6_second_grant", 32'(grant_log[base + 1]), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
